// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory access path: FSM state
// encoding and access-direction constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter with synchronous clear; reached flags the
// enabled cycle that brings the count up to LIMIT.
module timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign reached = enable && (count_reg == CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences EX/MEM loads and stores onto a req/ack memory port, holding
// the pipeline while an access is outstanding and flagging timeouts.
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              error_o
);

  state_t            state_reg, state_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              valid_reg, valid_next;
  logic              error_reg, error_next;
  logic              stall;
  logic              timed_out;

  // Counter only runs while waiting in REQ; it is cleared everywhere else
  // so each access starts from zero.
  timeout_counter #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .clear  (state_reg != S_REQ),
    .enable ((state_reg == S_REQ) && !mem_ack_i),
    .reached(timed_out)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= S_IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      valid_reg <= valid_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    valid_next = valid_reg;
    error_next = error_reg;
    stall      = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        stall = MemRead_i | MemWrite_i;
        if (MemRead_i || MemWrite_i) begin
          // A simultaneous read and write is issued as the write.
          we_next    = MemWrite_i ? ACC_WRITE : ACC_READ;
          addr_next  = addr_i;
          wdata_next = wdata_i;
          req_next   = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_ack_i) begin
          req_next = 1'b0;
          if (we_reg == ACC_READ) begin
            rdata_next = mem_rdata_i;
            valid_next = 1'b1;
          end
          state_next = S_DONE;
        end else if (timed_out) begin
          req_next   = 1'b0;
          error_next = 1'b1;
          if (we_reg == ACC_READ) begin
            rdata_next = '0;
            valid_next = 1'b1;
          end
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // EX/MEM still shows the finished instruction here, so no new
        // access is accepted until the following cycle.
        valid_next = 1'b0;
        state_next = S_IDLE;
      end
      default: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign mem_req_o     = req_reg;
  assign mem_we_o      = we_reg;
  assign mem_addr_o    = addr_reg;
  assign mem_wdata_o   = wdata_reg;
  assign stall_o       = stall;
  assign rdata_o       = rdata_reg;
  assign rdata_valid_o = valid_reg;
  assign error_o       = error_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus random
// accesses checked against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  // Model state: last completed read value and sticky error flag.
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;

  mem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req"}, mem_req_o, 0);
    check_val({tag, "_we"}, mem_we_o, 0);
    check_val({tag, "_addr"}, mem_addr_o, 0);
    check_val({tag, "_wdata"}, mem_wdata_o, 0);
    check_val({tag, "_rdata"}, rdata_o, 0);
    check_val({tag, "_valid"}, rdata_valid_o, 0);
    check_val({tag, "_err"}, error_o, 0);
    check_val({tag, "_stall"}, stall_o, 0);
  endtask

  // One pipeline instruction that accesses memory. ack_at is the REQ cycle
  // (1-based) on which memory acknowledges; values outside 1..TO never ack.
  // Entered and left at a negedge with the controller idle.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdv, input int ack_at);
    int  k;
    int  n_req;
    bit  is_wr;
    bit  to;
    is_wr = wr;
    to    = !(ack_at >= 1 && ack_at <= TO);
    n_req = to ? TO : ack_at;
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = wd;
    mem_ack_i  = 1'b0;
    #1 check_val("stall_detect", stall_o, 1);
    k = 0;
    forever begin
      @(negedge clk_i);
      if (!mem_req_o) break;
      k++;
      check_val("req_we", mem_we_o, is_wr);
      check_val("req_addr", mem_addr_o, a);
      check_val("req_wdata", mem_wdata_o, wd);
      check_val("req_stall", stall_o, 1);
      mem_ack_i   = (k == ack_at);
      mem_rdata_i = (k == ack_at) ? rdv : $urandom;
      if (k > TO + 1) begin
        check_val("req_bound", k, TO);
        break;
      end
    end
    mem_ack_i = 1'b0;
    check_val("req_cycles", k, n_req);
    check_val("done_stall", stall_o, 0);
    check_val("done_valid", rdata_valid_o, !is_wr);
    if (!is_wr) model_rdata = to ? 32'h0 : rdv;
    if (to) model_err = 1'b1;
    check_val("done_rdata", rdata_o, model_rdata);
    check_val("done_err", error_o, model_err);
    @(negedge clk_i);
    check_val("no_dup_req", mem_req_o, 0);
    check_val("valid_pulse", rdata_valid_o, 0);
    $display("ACC rd=%0d wr=%0d addr=%h ack_at=%0d req_cycles=%0d rdata=%h err=%0d",
             rd, wr, a, ack_at, k, rdata_o, error_o);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  task automatic idle_cycle(input logic stray_ack);
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    mem_ack_i   = stray_ack;
    mem_rdata_i = $urandom;
    #1 check_val("idle_stall", stall_o, 0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    check_val("idle_req", mem_req_o, 0);
    check_val("idle_valid", rdata_valid_o, 0);
    check_val("idle_rdata", rdata_o, model_rdata);
    check_val("idle_err", error_o, model_err);
    $display("IDLE stray_ack=%0d req=%0d", stray_ack, mem_req_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b1;
    @(negedge clk_i);

    run_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678, 3);
    run_access(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 32'h5A5A5A5A, 1);
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hA1B2C3D4, 2);
    run_access(1'b0, 1'b1, 32'h104, 32'h0BADF00D, 32'h77777777, 1);
    idle_cycle(1'b1);
    run_access(1'b1, 1'b0, 32'h200, 32'h0, 32'h13572468, TO);
    run_access(1'b1, 1'b1, 32'h300, 32'hFEEDBEEF, 32'h99999999, 2);
    run_access(1'b1, 1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 0);

    for (int i = 0; i < 40; i++) begin
      logic rd;
      logic wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr)
        idle_cycle(1'($urandom_range(0, 1)));
      else
        run_access(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 6));
    end

    // Reset while a read is waiting in REQ.
    MemRead_i = 1'b1;
    addr_i    = 32'h500;
    @(negedge clk_i);
    @(negedge clk_i);
    check_val("pre_rst_req", mem_req_o, 1);
    #1;
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    #1 check_all_zero("async_rst");
    model_err   = 1'b0;
    model_rdata = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_val("no_retry_req", mem_req_o, 0);
    end
    run_access(1'b1, 1'b0, 32'h600, 32'h0, 32'h2468ACE0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
